// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: 3-wide common-data-bus producer with per-FU holding registers and
// round-robin selection. Define CDB_STALL_CNT_EN to add the saturating stall_cnt output.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif
`ifndef SYS_ZERO_PHYS_REG
`define SYS_ZERO_PHYS_REG {`SYS_PHYS_REG{1'b0}}
`endif
`ifndef CDB_T_PACKET
`define CDB_T_PACKET logic [2:0][`SYS_PHYS_REG-1:0]
`endif

module cdb_broadcaster #(
    parameter int NUM_FU = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                squash,
    input  logic [NUM_FU-1:0]                   fu_valid,
    input  logic [NUM_FU-1:0][`SYS_PHYS_REG-1:0] fu_tag,
    input  logic [NUM_FU-1:0][`SYS_XLEN-1:0]    fu_data,
    output logic [NUM_FU-1:0]                   fu_ready,
    output `CDB_T_PACKET                        cdb_tag,
    output logic [2:0][`SYS_XLEN-1:0]           cdb_data
`ifdef CDB_STALL_CNT_EN
    ,
    output logic [31:0]                         stall_cnt
`endif
);

    localparam int PW = `SYS_PHYS_REG;
    localparam int XW = `SYS_XLEN;
    localparam int IW = $clog2(NUM_FU);
    localparam int SW = IW + 1;
    localparam logic [PW-1:0] ZERO_TAG = `SYS_ZERO_PHYS_REG;
    localparam logic [SW-1:0] NUM_FU_S = SW'(NUM_FU);
    localparam logic [IW-1:0] LAST_FU  = IW'(NUM_FU - 1);

    logic [NUM_FU-1:0]          hv;
    logic [NUM_FU-1:0][PW-1:0]  ht;
    logic [NUM_FU-1:0][XW-1:0]  hd;
    logic [IW-1:0]              rr;

    logic [NUM_FU-1:0]          grant;
    logic [2:0]                 slot_use;
    logic [2:0][IW-1:0]         slot_idx;
    logic [IW-1:0]              last_idx;
    logic [IW-1:0]              next_rr;
    logic [1:0]                 gcnt;
    logic [SW-1:0]              scan_raw;
    logic [IW-1:0]              cand;

    // Scan from rr with wrap-around; first three valid holders fill t0, t1, t2 in order
    always_comb begin
        grant    = '0;
        slot_use = 3'b000;
        slot_idx = '0;
        last_idx = rr;
        gcnt     = 2'd0;
        scan_raw = '0;
        cand     = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_raw = {1'b0, rr} + SW'(k);
            cand     = (scan_raw >= NUM_FU_S) ? IW'(scan_raw - NUM_FU_S) : scan_raw[IW-1:0];
            if (hv[cand] && (gcnt != 2'd3)) begin
                grant[cand]    = 1'b1;
                slot_use[gcnt] = 1'b1;
                slot_idx[gcnt] = cand;
                last_idx       = cand;
                gcnt           = gcnt + 2'd1;
            end else begin
            end
        end
        next_rr = (last_idx == LAST_FU) ? '0 : last_idx + IW'(1);
    end

    // A holder is free when empty or draining this cycle; never ready while in reset
    always_comb begin
        fu_ready = {NUM_FU{~rst}} & (~hv | grant);
    end

    // Holder valid bits, round-robin pointer and registered broadcast slots
    always_ff @(posedge clk) begin
        if (rst || squash) begin
            hv       <= '0;
            rr       <= '0;
            cdb_tag  <= {3{ZERO_TAG}};
            cdb_data <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (fu_valid[i] && fu_ready[i]) begin
                    hv[i] <= (fu_tag[i] != ZERO_TAG);
                end else if (grant[i]) begin
                    hv[i] <= 1'b0;
                end else begin
                    hv[i] <= hv[i];
                end
            end
            rr <= (|grant) ? next_rr : rr;
            for (int s = 0; s < 3; s++) begin
                cdb_tag[s]  <= slot_use[s] ? ht[slot_idx[s]] : ZERO_TAG;
                cdb_data[s] <= slot_use[s] ? hd[slot_idx[s]] : '0;
            end
        end
    end

    // Payload capture; contents are only meaningful while the matching hv bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (fu_valid[i] && fu_ready[i]) begin
                ht[i] <= fu_tag[i];
                hd[i] <= fu_data[i];
            end else begin
                ht[i] <= ht[i];
                hd[i] <= hd[i];
            end
        end
    end

`ifdef CDB_STALL_CNT_EN
    logic stall_any;

    // A stall cycle is one where some held result is left waiting
    always_comb begin
        stall_any = |(hv & ~grant);
    end

    // Saturating stall counter; squash deliberately leaves it untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 32'd0;
        end else if (stall_any && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end else begin
            stall_cnt <= stall_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Scoreboard bench for cdb_broadcaster: a queue-based reference model predicts each
// broadcast, and a monitor compares the registered CDB outputs every cycle.
`ifndef SYS_PHYS_REG
`define SYS_PHYS_REG 6
`endif
`ifndef SYS_XLEN
`define SYS_XLEN 32
`endif
`ifndef SYS_ZERO_PHYS_REG
`define SYS_ZERO_PHYS_REG {`SYS_PHYS_REG{1'b0}}
`endif

module tb_cdb_broadcaster;

    localparam int N  = 8;
    localparam int PW = `SYS_PHYS_REG;
    localparam int XW = `SYS_XLEN;
    localparam logic [PW-1:0] ZT = `SYS_ZERO_PHYS_REG;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   squash;
    logic [N-1:0]           fu_valid;
    logic [N-1:0][PW-1:0]   fu_tag;
    logic [N-1:0][XW-1:0]   fu_data;
    logic [N-1:0]           fu_ready;
    logic [2:0][PW-1:0]     cdb_tag;
    logic [2:0][XW-1:0]     cdb_data;
`ifdef CDB_STALL_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    always #5 clk = ~clk;

    cdb_broadcaster #(.NUM_FU(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .squash   (squash),
        .fu_valid (fu_valid),
        .fu_tag   (fu_tag),
        .fu_data  (fu_data),
        .fu_ready (fu_ready),
        .cdb_tag  (cdb_tag),
        .cdb_data (cdb_data)
`ifdef CDB_STALL_CNT_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic [2:0][PW-1:0] tag;
        logic [2:0][XW-1:0] data;
        logic [31:0]        stall;
    } bc_t;

    bc_t          exp_q[$];
    bit           m_hv[N];
    logic [PW-1:0] m_t[N];
    logic [XW-1:0] m_d[N];
    int           m_rr;
    longint       m_stall;
    int           checks = 0;
    int           errors = 0;

    // One clock of the reference model: check ready, predict the post-edge broadcast
    task automatic step();
        int           g[$];
        bit           gr[N];
        logic [N-1:0] exp_rdy;
        bit           waiting;
        bc_t          e;
        #1;
        for (int i = 0; i < N; i++) gr[i] = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (m_hv[idx] && g.size() < 3) begin
                g.push_back(idx);
                gr[idx] = 1'b1;
            end
        end
        waiting = 1'b0;
        for (int i = 0; i < N; i++) begin
            exp_rdy[i] = !rst && (!m_hv[i] || gr[i]);
            if (m_hv[i] && !gr[i]) waiting = 1'b1;
        end
        checks++;
        if (fu_ready !== exp_rdy) begin
            errors++;
            $display("FAIL fu_ready t=%0t got=%b exp=%b", $time, fu_ready, exp_rdy);
        end
        for (int s = 0; s < 3; s++) begin
            e.tag[s]  = ZT;
            e.data[s] = '0;
        end
        if (rst) begin
            for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
            m_rr    = 0;
            m_stall = 0;
        end else begin
            if (waiting && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (squash) begin
                for (int i = 0; i < N; i++) m_hv[i] = 1'b0;
                m_rr = 0;
            end else begin
                for (int s = 0; s < g.size(); s++) begin
                    e.tag[s]  = m_t[g[s]];
                    e.data[s] = m_d[g[s]];
                    m_hv[g[s]] = 1'b0;
                end
                if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % N;
                for (int i = 0; i < N; i++) begin
                    if (fu_valid[i] && exp_rdy[i] && fu_tag[i] != ZT) begin
                        m_hv[i] = 1'b1;
                        m_t[i]  = fu_tag[i];
                        m_d[i]  = fu_data[i];
                    end
                end
            end
        end
        e.stall = 32'(m_stall);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        fu_valid = '0;
        fu_tag   = '0;
        fu_data  = '0;
        squash   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // Monitor: pop the prediction for the edge just taken and compare the CDB
    always @(posedge clk) begin
        bc_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (cdb_tag !== e.tag) begin
                errors++;
                $display("FAIL cdb_tag t=%0t got=%h exp=%h", $time, cdb_tag, e.tag);
            end
            checks++;
            if (cdb_data !== e.data) begin
                errors++;
                $display("FAIL cdb_data t=%0t got=%h exp=%h", $time, cdb_data, e.data);
            end
`ifdef CDB_STALL_CNT_EN
            checks++;
            if (stall_cnt !== e.stall) begin
                errors++;
                $display("FAIL stall_cnt t=%0t got=%0d exp=%0d", $time, stall_cnt, e.stall);
            end
`endif
        end
    end

    initial begin
        int dens;
        for (int i = 0; i < N; i++) begin
            m_hv[i] = 1'b0;
            m_t[i]  = '0;
            m_d[i]  = '0;
        end
        m_rr    = 0;
        m_stall = 0;
        rst     = 1'b1;
        idle_inputs();
        repeat (3) step();
        rst = 1'b0;
        step();

        // single result on FU2
        fu_valid[2] = 1'b1;
        fu_tag[2]   = PW'(5);
        fu_data[2]  = XW'(32'hDEAD);
        step();
        idle_inputs();
        repeat (3) step();

        // oversubscription: FU0..FU4 tags 10..14
        do_reset();
        for (int i = 0; i < 5; i++) begin
            fu_valid[i] = 1'b1;
            fu_tag[i]   = PW'(10 + i);
            fu_data[i]  = XW'($urandom);
        end
        step();
        idle_inputs();
        repeat (3) step();

        // fairness: all FUs valid every cycle with distinct tags
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) begin
                fu_valid[i] = 1'b1;
                fu_tag[i]   = PW'(((c * N + i) % 63) + 1);
                fu_data[i]  = XW'($urandom);
            end
            step();
        end
        idle_inputs();
        repeat (4) step();

        // zero tag is accepted and dropped
        fu_valid[1] = 1'b1;
        fu_tag[1]   = ZT;
        fu_data[1]  = XW'(32'h1234);
        step();
        idle_inputs();
        repeat (2) step();

        // squash the cycle after the first grant
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fu_valid[i] = 1'b1;
            fu_tag[i]   = PW'(20 + i);
            fu_data[i]  = XW'($urandom);
        end
        step();
        idle_inputs();
        step();
        squash = 1'b1;
        step();
        squash = 1'b0;
        repeat (3) step();

        // randomized traffic with occasional squash and reset
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(1, 4);
            rst    = ($urandom_range(0, 399) == 0);
            squash = ($urandom_range(0, 39) == 0);
            for (int i = 0; i < N; i++) begin
                fu_valid[i] = ($urandom_range(0, 4) < dens);
                fu_tag[i]   = ($urandom_range(0, 7) == 0) ? ZT : PW'($urandom);
                fu_data[i]  = XW'($urandom);
            end
            step();
        end
        rst = 1'b0;
        idle_inputs();
        repeat (4) step();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
